sad_result_ctrl: RTL

//  Initiator side of the 128x32 SAD result SRAM port (Addr/RW/En/Data_In/Data_Out).

---
 rtl/sad_pkg.sv | 17 +
 rtl/sad_result_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sad_pkg.sv
// sad_pkg: shared definitions for the SAD result path.
//   SAD_ADDR_W / SAD_DATA_W : default result SRAM geometry (128 x 32)
//   DEPTH                   : number of SRAM entries
//   sad_state_e             : result controller state encoding
package sad_pkg;

    localparam int SAD_ADDR_W = 7;
    localparam int SAD_DATA_W = 32;
    localparam int DEPTH      = 2 ** SAD_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2
    } sad_state_e;

endpackage

// File: rtl/sad_result_ctrl.sv
// sad_result_ctrl: initiator side of the SAD result SRAM.
// Stores SAD results arriving on a valid/ready stream at consecutive
// addresses, and on Start_Dump reads every stored entry back in address
// order as a dump stream. The SRAM is the only storage.
//
// Ports
//   Clk, Rst                  clock, asynchronous active-high reset
//   Res_Valid/Res_Data/Res_Ready   result input stream
//   Start_Dump, Clear         one-cycle command pulses (acted on in IDLE only)
//   Dump_Valid/Data/Last      read-back stream, no backpressure
//   Dump_Done                 pulse the cycle after the final dump word
//   Count, Full, Busy         status
//   Sram_Addr/En/RW/Wdata     registered SRAM command (RW: 1=write, 0=read)
//   Sram_Rdata                SRAM read data, one cycle after a read
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | accepting results; waiting for Start_Dump / Clear
// RD    | one SRAM read issued per cycle, addresses 0..Count-1
// DRAIN | last read data returning; buffer emptied on exit
module sad_result_ctrl
    import sad_pkg::*;
#(
    parameter int ADDR_W = SAD_ADDR_W,
    parameter int DATA_W = SAD_DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Res_Valid,
    input  logic [DATA_W-1:0] Res_Data,
    output logic              Res_Ready,
    input  logic              Start_Dump,
    input  logic              Clear,
    output logic              Dump_Valid,
    output logic [DATA_W-1:0] Dump_Data,
    output logic              Dump_Last,
    output logic              Dump_Done,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Busy,
    output logic [ADDR_W-1:0] Sram_Addr,
    output logic              Sram_En,
    output logic              Sram_RW,
    output logic [DATA_W-1:0] Sram_Wdata,
    input  logic [DATA_W-1:0] Sram_Rdata
);

    localparam int               CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 ** ADDR_W);

    sad_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic              sram_en_d, sram_rw_d;
    logic [ADDR_W-1:0] sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_d;
    logic              dump_valid_d, dump_last_d, dump_done_d;

    logic              accept;
    logic              rd_last;

    assign Full      = (count_q == CNT_FULL);
    assign Busy      = (state_q != IDLE);
    assign Count     = count_q;
    // Held low during reset so every output reads 0 while Rst is high.
    assign Res_Ready = !Rst && (state_q == IDLE) && !Full && !Start_Dump && !Clear;
    assign accept    = Res_Valid && Res_Ready;

    // rd_ptr_q is the address of the read on the SRAM port this cycle.
    assign rd_last   = (state_q == RD) && ({1'b0, rd_ptr_q} == (count_q - 1'b1));

    // SRAM returns zero when not reading; gating keeps Dump_Data clean
    // across reset as well.
    assign Dump_Data = Dump_Valid ? Sram_Rdata : '0;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        sram_en_d    = 1'b0;
        sram_rw_d    = 1'b0;
        sram_addr_d  = '0;
        sram_wdata_d = '0;
        dump_done_d  = 1'b0;
        dump_valid_d = Sram_En && !Sram_RW;
        dump_last_d  = Sram_En && !Sram_RW && rd_last;

        case (state_q)
            IDLE: begin
                if (Start_Dump) begin
                    if (count_q != '0) begin
                        state_d     = RD;
                        rd_ptr_d    = '0;
                        sram_en_d   = 1'b1;
                        sram_addr_d = '0;
                    end else begin
                        dump_done_d = 1'b1;
                    end
                end else if (Clear) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (accept) begin
                    sram_en_d    = 1'b1;
                    sram_rw_d    = 1'b1;
                    sram_addr_d  = wr_ptr_q;
                    sram_wdata_d = Res_Data;
                    wr_ptr_d     = wr_ptr_q + 1'b1;
                    count_d      = count_q + 1'b1;
                end
            end
            RD: begin
                if (rd_last) begin
                    state_d = DRAIN;
                end else begin
                    rd_ptr_d    = rd_ptr_q + 1'b1;
                    sram_en_d   = 1'b1;
                    sram_addr_d = rd_ptr_q + 1'b1;
                end
            end
            DRAIN: begin
                state_d     = IDLE;
                dump_done_d = 1'b1;
                count_d     = '0;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            Sram_En    <= 1'b0;
            Sram_RW    <= 1'b0;
            Sram_Addr  <= '0;
            Sram_Wdata <= '0;
            Dump_Valid <= 1'b0;
            Dump_Last  <= 1'b0;
            Dump_Done  <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            Sram_En    <= sram_en_d;
            Sram_RW    <= sram_rw_d;
            Sram_Addr  <= sram_addr_d;
            Sram_Wdata <= sram_wdata_d;
            Dump_Valid <= dump_valid_d;
            Dump_Last  <= dump_last_d;
            Dump_Done  <= dump_done_d;
        end
    end

endmodule
